// File: rtl/sfr_pkg.sv
// Shared types for the SFR bus arbiter: SFR address map, arbiter states and round-robin pick.
// Used by rr_arb2 and sfr_bus_arbiter; optional lock build is selected by SFR_ARB_LOCK_EN.
package sfr_pkg;

    localparam int NREQ = 2;

    typedef enum logic [7:0] {
        NOP        = 8'd0,
        PWM_PERIOD = 8'd1,
        PWM1_DUTY  = 8'd2,
        PWM2_DUTY  = 8'd3,
        PWM3_DUTY  = 8'd4,
        ENC        = 8'd5,
        SOUT       = 8'd6
    } sfr_addr_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_HOLD    = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_ACK     = 3'd5
    } arb_state_t;

    // Contention goes to the requester that did not win last time.
    function automatic logic rr_pick(input logic [NREQ-1:0] req, input logic last_grant);
        logic id;
        case (req)
            2'b01:   id = 1'b0;
            2'b10:   id = 1'b1;
            2'b11:   id = ~last_grant;
            default: id = last_grant;
        endcase
        return id;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker with last_grant pointer.
// With SFR_ARB_LOCK_EN defined, a locked grant pins later grants to the lock owner.
module rr_arb2
    import sfr_pkg::*;
(
    input  logic            clk,
    input  logic            nrst,
    input  logic [NREQ-1:0] req,
`ifdef SFR_ARB_LOCK_EN
    input  logic [NREQ-1:0] req_lock,
    input  logic            idle,
`endif
    input  logic            take,
    output logic            gnt_valid,
    output logic            gnt_id
);

    logic last_grant_q, last_grant_d;

`ifdef SFR_ARB_LOCK_EN
    logic lock_act_q, lock_act_d;
    logic lock_own_q, lock_own_d;
    logic held_s;

    // A held lock restricts the grant to its owner, even while the owner is quiet
    always_comb begin
        held_s = lock_act_q & req_lock[lock_own_q];
        if (held_s) begin
            gnt_valid = req[lock_own_q];
            gnt_id    = lock_own_q;
        end else begin
            gnt_valid = |req;
            gnt_id    = rr_pick(req, last_grant_q);
        end
    end

    // Lock is taken on a locked grant and released once the owner drops req_lock in IDLE
    always_comb begin
        lock_act_d = lock_act_q;
        lock_own_d = lock_own_q;
        if (take && req_lock[gnt_id]) begin
            lock_act_d = 1'b1;
            lock_own_d = gnt_id;
        end else if (idle && !held_s) begin
            lock_act_d = 1'b0;
        end else begin
            lock_act_d = lock_act_q;
        end
    end

    // Lock state register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            lock_act_q <= 1'b0;
            lock_own_q <= 1'b0;
        end else begin
            lock_act_q <= lock_act_d;
            lock_own_q <= lock_own_d;
        end
    end
`else
    // Plain round-robin pick
    always_comb begin
        gnt_valid = |req;
        gnt_id    = rr_pick(req, last_grant_q);
    end
`endif

    // Pointer moves only when a grant is actually committed
    always_comb begin
        if (take) begin
            last_grant_d = gnt_id;
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // Pointer resets to 1 so requester 0 wins the first contention
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/sfr_bus_arbiter.sv
// Shares the SFR port between CPU (req 0) and debug host (req 1) with setup/strobe/hold sequencing.
// Optional SFR_ARB_LOCK_EN adds req_lock for owner-pinned grants.
module sfr_bus_arbiter
    import sfr_pkg::*;
#(
    parameter int SETUP_CYCLES = 1,
    parameter int HOLD_CYCLES  = 1
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic [NREQ-1:0] req_valid,
    input  logic [NREQ-1:0] req_we,
    input  logic [15:0]     req_addr,
    input  logic [15:0]     req_wdata,
`ifdef SFR_ARB_LOCK_EN
    input  logic [NREQ-1:0] req_lock,
`endif
    output logic [NREQ-1:0] req_ack,
    output logic [7:0]      req_rdata,
    output logic [7:0]      sfr_addr,
    output logic [7:0]      sfr_write_val,
    output logic            sfr_write_valid,
    input  logic [7:0]      sfr_read_val,
    output logic            busy,
    output logic            grant_id
);

    arb_state_t      state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [7:0]      addr_q, addr_d;
    logic [7:0]      wval_q, wval_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            we_q, we_d;
    logic            wv_q, wv_d;
    logic            gid_q, gid_d;
    logic            busy_q, busy_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            idle_s, take_s, gnt_valid_s, gnt_id_s;

    assign idle_s = (state_q == ST_IDLE);
    assign take_s = idle_s & gnt_valid_s;

    rr_arb2 u_rr (
        .clk       (clk),
        .nrst      (nrst),
        .req       (req_valid),
`ifdef SFR_ARB_LOCK_EN
        .req_lock  (req_lock),
        .idle      (idle_s),
`endif
        .take      (take_s),
        .gnt_valid (gnt_valid_s),
        .gnt_id    (gnt_id_s)
    );

    // Access sequencer: payload is latched at grant so later requester changes are ignored
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wval_d  = wval_q;
        we_d    = we_q;
        gid_d   = gid_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                addr_d = 8'h00;
                if (take_s) begin
                    addr_d  = gnt_id_s ? req_addr[15:8]  : req_addr[7:0];
                    wval_d  = gnt_id_s ? req_wdata[15:8] : req_wdata[7:0];
                    we_d    = req_we[gnt_id_s];
                    gid_d   = gnt_id_s;
                    cnt_d   = 8'(SETUP_CYCLES - 1);
                    state_d = ST_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    state_d = we_q ? ST_STROBE : ST_CAPTURE;
                end
            end
            ST_STROBE: begin
                cnt_d   = 8'(HOLD_CYCLES - 1);
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    state_d = ST_ACK;
                end
            end
            ST_CAPTURE: begin
                rdata_d = sfr_read_val;
                state_d = ST_ACK;
            end
            ST_ACK: begin
                addr_d  = 8'h00;
                state_d = ST_IDLE;
            end
            default: begin
                addr_d  = 8'h00;
                state_d = ST_IDLE;
            end
        endcase
        // Strobe, busy and ack are decoded from the next state so they leave a flop cleanly
        wv_d   = (state_d == ST_STROBE);
        busy_d = (state_d != ST_IDLE);
        if (state_d == ST_ACK) begin
            ack_d = gid_q ? 2'b10 : 2'b01;
        end else begin
            ack_d = 2'b00;
        end
    end

    // Sequencer and output registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            addr_q  <= 8'h00;
            wval_q  <= 8'h00;
            rdata_q <= 8'h00;
            we_q    <= 1'b0;
            wv_q    <= 1'b0;
            gid_q   <= 1'b0;
            busy_q  <= 1'b0;
            ack_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wval_q  <= wval_d;
            rdata_q <= rdata_d;
            we_q    <= we_d;
            wv_q    <= wv_d;
            gid_q   <= gid_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
        end
    end

    assign req_ack         = ack_q;
    assign req_rdata       = rdata_q;
    assign sfr_addr        = addr_q;
    assign sfr_write_val   = wval_q;
    assign sfr_write_valid = wv_q;
    assign busy            = busy_q;
    assign grant_id        = gid_q;

endmodule

// File: tb/tb_sfr_bus_arbiter.sv
// Directed bench for sfr_bus_arbiter: default timing instance plus a SETUP=3/HOLD=2 instance.
// Lock scenario is compiled only when SFR_ARB_LOCK_EN is defined.
module tb_sfr_bus_arbiter;
    import sfr_pkg::*;

    logic clk = 1'b0;
    logic nrst;
    int   checks = 0;
    int   errors = 0;

    logic [1:0]  req_valid, req_we, req_ack;
    logic [15:0] req_addr, req_wdata;
    logic [7:0]  req_rdata, sfr_addr, sfr_write_val, sfr_read_val;
    logic        sfr_write_valid, busy, grant_id;

    logic [1:0]  v3, we3, ack3;
    logic [15:0] addr3, wdata3;
    logic [7:0]  rdata3, saddr3, swval3;
    logic        swv3, busy3, gid3;
`ifdef SFR_ARB_LOCK_EN
    logic [1:0]  req_lock, lock3;
`endif

    always #5 clk = ~clk;

    sfr_bus_arbiter dut (
        .clk(clk), .nrst(nrst), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef SFR_ARB_LOCK_EN
        .req_lock(req_lock),
`endif
        .req_ack(req_ack), .req_rdata(req_rdata), .sfr_addr(sfr_addr),
        .sfr_write_val(sfr_write_val), .sfr_write_valid(sfr_write_valid),
        .sfr_read_val(sfr_read_val), .busy(busy), .grant_id(grant_id)
    );

    sfr_bus_arbiter #(.SETUP_CYCLES(3), .HOLD_CYCLES(2)) dut3 (
        .clk(clk), .nrst(nrst), .req_valid(v3), .req_we(we3),
        .req_addr(addr3), .req_wdata(wdata3),
`ifdef SFR_ARB_LOCK_EN
        .req_lock(lock3),
`endif
        .req_ack(ack3), .req_rdata(rdata3), .sfr_addr(saddr3),
        .sfr_write_val(swval3), .sfr_write_valid(swv3),
        .sfr_read_val(8'h00), .busy(busy3), .grant_id(gid3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) until the default instance acks; returns with ack visible or on timeout
    task automatic wait_ack();
        int cyc;
        cyc = 0;
        while (req_ack === 2'b00 && cyc < 12) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        logic [1:0] exp_ack;
        int         hi_cnt, rise_cnt;
        logic       prev_wv;

        nrst = 1'b0; req_valid = 2'b00; req_we = 2'b00; req_addr = 16'h0; req_wdata = 16'h0;
        sfr_read_val = 8'h00; v3 = 2'b00; we3 = 2'b00; addr3 = 16'h0; wdata3 = 16'h0;
`ifdef SFR_ARB_LOCK_EN
        req_lock = 2'b00; lock3 = 2'b00;
`endif
        tick(); tick();
        chk("rst_addr", sfr_addr, 8'h00);
        chk("rst_wv", sfr_write_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ack", req_ack, 2'b00);
        chk("rst_rdata", req_rdata, 8'h00);
        chk("rst_gid", grant_id, 1'b0);
        nrst = 1'b1;
        tick(); tick();
        chk("idle_addr", sfr_addr, 8'h00);
        chk("idle_busy", busy, 1'b0);

        // Write 0x80 to PWM_PERIOD from requester 0
        req_valid = 2'b01; req_we = 2'b01; req_addr = {8'h00, PWM_PERIOD}; req_wdata = 16'h0080;
        tick();
        chk("wr_n1_addr", sfr_addr, 8'h01);
        chk("wr_n1_val", sfr_write_val, 8'h80);
        chk("wr_n1_wv", sfr_write_valid, 1'b0);
        chk("wr_n1_busy", busy, 1'b1);
        tick();
        chk("wr_n2_wv", sfr_write_valid, 1'b1);
        chk("wr_n2_addr", sfr_addr, 8'h01);
        chk("wr_n2_ack", req_ack, 2'b00);
        tick();
        chk("wr_n3_wv", sfr_write_valid, 1'b0);
        chk("wr_n3_val", sfr_write_val, 8'h80);
        chk("wr_n3_addr", sfr_addr, 8'h01);
        tick();
        chk("wr_n4_ack", req_ack, 2'b01);
        req_valid = 2'b00;
        tick();
        chk("wr_done_ack", req_ack, 2'b00);
        chk("wr_done_addr", sfr_addr, 8'h00);
        chk("wr_done_busy", busy, 1'b0);

        // Read ENC (5) from requester 1
        req_valid = 2'b10; req_we = 2'b00; req_addr = {ENC, 8'h00}; sfr_read_val = 8'h3C;
        tick();
        chk("rd_n1_addr", sfr_addr, 8'h05);
        chk("rd_n1_gid", grant_id, 1'b1);
        tick();
        chk("rd_n2_ack", req_ack, 2'b00);
        tick();
        chk("rd_n3_ack", req_ack, 2'b10);
        chk("rd_n3_data", req_rdata, 8'h3C);
        req_valid = 2'b00; sfr_read_val = 8'h99;
        tick();

        // Requester 0 write that drops valid and scrambles payload after grant
        req_valid = 2'b01; req_we = 2'b01; req_addr = {8'h00, PWM1_DUTY}; req_wdata = 16'h0011;
        tick();
        req_valid = 2'b00; req_addr = 16'hFFFF; req_wdata = 16'hFFFF; req_we = 2'b00;
        tick();
        chk("viol_addr", sfr_addr, 8'h02);
        chk("viol_val", sfr_write_val, 8'h11);
        chk("viol_wv", sfr_write_valid, 1'b1);
        tick(); tick();
        chk("viol_ack", req_ack, 2'b01);
        chk("rdata_hold", req_rdata, 8'h3C);
        tick();

        // Async reset in the middle of a strobe
        req_valid = 2'b01; req_we = 2'b01; req_addr = {8'h00, SOUT}; req_wdata = 16'h0055;
        tick(); tick();
        chk("pre_rst_wv", sfr_write_valid, 1'b1);
        #2 nrst = 1'b0;
        #1;
        chk("async_wv", sfr_write_valid, 1'b0);
        chk("async_addr", sfr_addr, 8'h00);
        chk("async_busy", busy, 1'b0);
        req_valid = 2'b00;
        tick();
        nrst = 1'b1;
        tick();
        chk("post_rst_ack", req_ack, 2'b00);

        // Continuous contention alternates 0,1,0,1 from reset
        req_valid = 2'b11; req_we = 2'b00; req_addr = {8'h04, 8'h03}; sfr_read_val = 8'h21;
        for (int t = 0; t < 4; t++) begin
            exp_ack = (t % 2 == 1) ? 2'b10 : 2'b01;
            wait_ack();
            chk("rr_ack", req_ack, exp_ack);
            chk("rr_gid", grant_id, exp_ack[1]);
            if (t == 3) begin
                req_valid = 2'b00;
            end
            tick();
        end

        // Stretched timing: SOUT write of 0x41 with SETUP=3, HOLD=2
        v3 = 2'b01; we3 = 2'b01; addr3 = {8'h00, SOUT}; wdata3 = 16'h0041;
        hi_cnt = 0; rise_cnt = 0; prev_wv = swv3;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (swv3 === 1'b1) hi_cnt++;
            if (swv3 === 1'b1 && prev_wv !== 1'b1) rise_cnt++;
            prev_wv = swv3;
            if (k == 4) chk("s3_strobe", swv3, 1'b1);
            if (k == 3) chk("s3_pre", swv3, 1'b0);
            if (k == 6) chk("s3_hold_addr", saddr3, 8'h06);
            if (k == 7) begin
                chk("s3_ack", ack3, 2'b01);
                chk("s3_val", swval3, 8'h41);
                v3 = 2'b00;
            end
        end
        chk("s3_rises", rise_cnt, 1);
        chk("s3_high", hi_cnt, 1);

`ifdef SFR_ARB_LOCK_EN
        // Locked requester 0 keeps the bus for three grants, then requester 1 gets it
        req_valid = 2'b11; req_we = 2'b00; req_lock = 2'b01;
        for (int t = 0; t < 3; t++) begin
            wait_ack();
            chk("lock_ack", req_ack, 2'b01);
            if (t == 2) begin
                req_lock = 2'b00;
                req_valid = 2'b10;
            end
            tick();
        end
        wait_ack();
        chk("unlock_ack", req_ack, 2'b10);
        req_valid = 2'b00;
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
